// File: rtl/switch_rr_arbiter_pkg.sv
// Shared constants, state encoding and the round-robin winner search
// for the packet-locking stream arbiter.
package switch_rr_arbiter_pkg;

  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_NONE = 3'b111;
  localparam int MAX_INPUTS = 7;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_result_t;

  // Scans ptr+1, ptr+2, ... modulo n and returns the first valid requester.
  // ptr is always < n, so a single conditional subtract implements the wrap.
  function automatic rr_result_t rr_winner(input logic [7:0]       valid,
                                           input logic [SEL_W-1:0] ptr,
                                           input logic [3:0]       n);
    rr_result_t res;
    logic [3:0] cand;
    res.found = 1'b0;
    res.idx   = SEL_NONE;
    for (int k = 1; k <= MAX_INPUTS; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= n) cand = cand - n;
      if ((4'(k) <= n) && !res.found && valid[cand[2:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/switch_rr_arbiter_out_reg.sv
// One-entry registered output stage; accepts a new word whenever it is
// empty or the downstream is draining it this cycle.
module switch_rr_arbiter_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  out_ready_i,
  output logic                  load_en_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  last_o
);

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  last_q;

  assign load_en_o = !valid_q || out_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_en_o) begin
      valid_q <= load_i;
      if (load_i) begin
        data_q <= data_i;
        last_q <= last_i;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule

// File: rtl/switch_rr_arbiter.sv
// Round-robin, packet-locking arbiter driving the shared N:1 mux select and
// a registered output stage.
//
// state  | meaning
// IDLE   | no packet in flight; grant goes to the round-robin winner
// LOCKED | owner_q is mid-packet; only the owner may transfer
module switch_rr_arbiter
  import switch_rr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int INPUTS     = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [INPUTS-1:0]            in_valid,
  input  logic [INPUTS-1:0]            in_last,
  output logic [INPUTS-1:0]            in_ready,
  output logic [SEL_W-1:0]             sel,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ready
);

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      owner_q, owner_d;
  logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic [7:0]            valid_ext;
  rr_result_t            win;
  logic                  grant_vld;
  logic [SEL_W-1:0]      grant_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;
  logic                  sel_valid;
  logic                  load_en;
  logic                  xfer;

  always_comb begin
    valid_ext             = '0;
    valid_ext[INPUTS-1:0] = in_valid;
  end

  assign win = rr_winner(valid_ext, rr_ptr_q, 4'(INPUTS));

  // While locked the grant sticks to the owner even if it drops valid.
  always_comb begin
    if (state_q == LOCKED) begin
      grant_vld = 1'b1;
      grant_idx = owner_q;
    end else begin
      grant_vld = win.found;
      grant_idx = win.idx;
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    in_ready = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (grant_vld && (grant_idx == 3'(i))) begin
        sel_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last    = in_last[i];
        in_ready[i] = load_en;
      end
    end
  end

  assign sel_valid = grant_vld && valid_ext[grant_idx];
  assign xfer      = sel_valid && load_en;
  assign sel       = grant_vld ? grant_idx : SEL_NONE;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      if ((state_q == IDLE) && !sel_last) begin
        state_d = LOCKED;
        owner_d = grant_idx;
      end else if (sel_last) begin
        state_d  = IDLE;
        rr_ptr_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= 3'(INPUTS - 1);
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  switch_rr_arbiter_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (xfer),
    .data_i     (sel_data),
    .last_i     (sel_last),
    .out_ready_i(out_ready),
    .load_en_o  (load_en),
    .data_o     (out_data),
    .valid_o    (out_valid),
    .last_o     (out_last)
  );

endmodule

// File: doc/switch_rr_arbiter.md
Name: switch_rr_arbiter

Overview:
- Round-robin, packet-locking arbiter that shares a single N:1 selection datapath between up to 7 valid/ready stream requesters.
- Generates the 3-bit select code for the mux, including the reserved "none" code that forces a zero output.
- Registers the selected word into a one-entry output stage.
- Sits in front of the statement-example mux family; it is the sequencing/sharing layer for them.

Parameters:
- DATA_WIDTH, 8, width of each input word and of out_data.
- INPUTS, 3, number of requesters; legal range 1..7. The select code 3'b111 is reserved for "none".

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_data  input  INPUTS*DATA_WIDTH  packed words; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  INPUTS  per-requester valid.
- in_last  input  INPUTS  per-requester end-of-packet flag, qualified by valid.
- in_ready  output  INPUTS  per-requester ready; at most one bit high in any cycle.
- sel  output  3  current grant index 0..INPUTS-1, or 3'b111 when no owner.
- out_data  output  DATA_WIDTH  registered selected word.
- out_valid  output  1  registered valid.
- out_last  output  1  registered last flag.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, rr_ptr=INPUTS-1 so input 0 has top priority first.
  - sel=3'b111, out_valid=0, out_data=0, out_last=0, in_ready=0.
  - Reset asserted mid-packet drops the partial packet. No output word is emitted for that cycle.
- Output stage:
  - load_en = !out_valid | out_ready.
  - A transfer on input i occurs when in_valid[i] & in_ready[i].
  - On a transfer, out_data/out_last load the selected word and flag, and out_valid is set on the next edge.
  - Without a transfer, out_valid clears if out_ready=1; otherwise it holds.
  - Throughput is 1 word/cycle; latency is 1 cycle from input handshake to out_valid.
- Arbitration, combinational in IDLE:
  - Search i = rr_ptr+1, rr_ptr+2, ... modulo INPUTS; the first asserted in_valid wins.
  - in_ready[winner] = load_en, and sel = winner in the same cycle.
  - If no in_valid is set, sel=3'b111 and in_ready=0.
- State machine:
  - IDLE -> LOCKED on a transfer with in_last=0. The owner is registered as the winner.
  - IDLE stays IDLE on a transfer with in_last=1 (single-word packet). rr_ptr becomes the winner.
  - LOCKED: sel=owner and in_ready[owner]=load_en. All other in_ready bits are 0.
  - Other requesters' valid is ignored while LOCKED.
  - If the owner drops valid, sel stays on the owner. No word is moved and there is no re-arbitration.
  - LOCKED -> IDLE on an owner transfer with in_last=1. rr_ptr becomes the owner.
  - sel returns to 3'b111 in the following cycle unless a new winner exists.
- rr_ptr updates only at packet end, i.e. a last transfer. This gives fairness per packet, not per word.
- Backpressure: when out_valid=1 and out_ready=0, all in_ready=0. sel still shows the pending grant.
- INPUTS=1: always grant input 0 when valid; the wrap-around reduces to a constant.
- in_valid bits at index >= INPUTS do not exist; sel never takes a value between INPUTS and 6.

Decomposition:
- Shared package holds:
  - SEL_NONE = 3'b111;
  - SEL_W = 3;
  - the state encoding enum {IDLE, LOCKED};
  - a function computing the round-robin winner (rotate by rr_ptr+1, priority-encode, rotate back) returning index and found flag.
- One sub-module is natural: switch_rr_arbiter_out_reg, the one-entry registered output stage with load_en.
- The arbiter FSM and the mux-select drive stay in the top module.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, all valid=0 -> sel=7, out_valid=0, out_data=0, in_ready=0.
- Fairness:
  - Stimulus: inputs 0, 1, 2 continuously valid with single-word packets (last=1) carrying data 0xA0, 0xB1, 0xC2; out_ready=1.
  - Required: grants cycle 0,1,2,0,...; out_data sequence A0,B1,C2,A0 starting 1 cycle after the first handshake.
- Packet lock:
  - Stimulus: input 1 sends a 3-word packet (0x11, 0x12, 0x13 with last on the third) while input 0 is valid.
  - Required: sel=1 for all three words; input 0 is granted only after 0x13; then input 2 wins over input 0 if both are valid.
- Backpressure:
  - Stimulus: out_ready=0 for 4 cycles mid-packet.
  - Required: out_valid=1 and out_data held; in_ready all 0; resuming out_ready=1 delivers the next word with no loss or duplication.
- Owner gap: the locked owner drops valid for 2 cycles while input 2 is valid -> sel holds the owner, input 2 in_ready=0, no out_valid.
- Reset mid-packet:
  - Stimulus: rst_n=0 during LOCKED on input 2.
  - Required: next cycle sel=7 and out_valid=0; after release, input 0 has first priority.
